// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: frame constants and loader state encoding.
package program_loader_pkg;

  localparam int LOADER_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD   = 4;
  localparam int XLEN             = 32;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word and flags the byte that completes it.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            accept,
  input  logic [7:0]      in_byte,
  output logic            word_ready,
  output logic [XLEN-1:0] word
);

  logic [1:0]      byte_cnt;
  logic [XLEN-9:0] shift;

  // The completing byte goes straight into the top lane, so the word is ready on that same edge.
  assign word_ready = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {in_byte, shift};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= {in_byte, shift[XLEN-9:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-serial program memory loader: parses a counted frame of words and holds the core in reset until it is written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  frame_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IW    = ADDR_WIDTH + 1;

  loader_state_t   state, state_nxt;
  logic [7:0]      hdr_lo;
  logic [15:0]     hdr_count;
  logic [15:0]     word_count;
  logic [IW-1:0]   word_idx;
  logic            accept;
  logic            last_write;
  logic            word_ready;
  logic [XLEN-1:0] asm_word;

  assign in_ready    = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign core_reset  = (state != RUN);
  assign load_done   = (state == RUN);
  assign frame_error = (state == ERROR);

  // A byte arriving together with load_req is swallowed by the restart.
  assign accept     = in_valid && in_ready && !load_req;
  assign hdr_count  = {in_byte, hdr_lo};
  assign last_write = wr_en && ((32'(word_idx) + 32'd1) == 32'(word_count));

  program_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_req),
    .accept     (accept && (state == DATA)),
    .in_byte    (in_byte),
    .word_ready (word_ready),
    .word       (asm_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = HDR0;
    end else begin
      case (state)
        HDR0: if (accept) state_nxt = HDR1;
        HDR1: begin
          if (accept) begin
            if (hdr_count == 16'd0)             state_nxt = RUN;
            else if (32'(hdr_count) > DEPTH)    state_nxt = ERROR;
            else                                state_nxt = DATA;
          end
        end
        DATA: if (last_write) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // Header capture, word indexing and the registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_lo     <= '0;
      word_count <= '0;
      word_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else if (load_req) begin
      hdr_lo     <= '0;
      word_count <= '0;
      word_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= word_ready;
      if (word_ready) begin
        wr_addr <= word_idx[ADDR_WIDTH-1:0];
        wr_data <= asm_word;
      end
      if (wr_en) word_idx <= word_idx + 1'b1;
      if (accept && (state == HDR0)) hdr_lo <= in_byte;
      if (accept && (state == HDR1)) word_count <= hdr_count;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized frames against a frame-level model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        load_req;

  logic        m_in_ready, m_wr_en, m_core_reset, m_load_done, m_frame_error;
  logic [7:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic        s_in_ready, s_wr_en, s_core_reset, s_load_done, s_frame_error;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [39:0] mq[$];
  logic [39:0] sq[$];
  logic [39:0] eq[$];
  logic [7:0]  fq[$];
  bit          exp_run, exp_err;

  program_loader #(.ADDR_WIDTH(8)) u_main (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(m_in_ready),
    .load_req(load_req), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .core_reset(m_core_reset), .load_done(m_load_done), .frame_error(m_frame_error)
  );

  program_loader #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(s_in_ready),
    .load_req(load_req), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .core_reset(s_core_reset), .load_done(s_load_done), .frame_error(s_frame_error)
  );

  always #5 clk = ~clk;

  // Every write strobe seen by either instance is logged for comparison against the model.
  always @(negedge clk) begin
    if (m_wr_en) mq.push_back({m_wr_addr, m_wr_data});
    if (s_wr_en) sq.push_back({6'b0, s_wr_addr, s_wr_data});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit sel, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      idle($urandom_range(0, 3));
    end
    in_byte  = b;
    in_valid = 1'b1;
    t = 0;
    while (((sel ? s_in_ready : m_in_ready) !== 1'b1) && t < 50) begin
      idle(1);
      t++;
    end
    if (t >= 50) check_output("ready_timeout", 64'(sel ? s_in_ready : m_in_ready), 64'd1);
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input bit gaps);
    foreach (fq[i]) apply_stimulus(fq[i], sel, gaps);
  endtask

  task automatic make_random_frame(input int n);
    fq.delete();
    fq.push_back(8'(n));
    fq.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) fq.push_back(8'($urandom));
  endtask

  // Frame-level model: decode the count, then slice the payload into little-endian words.
  task automatic build_model(input int depth);
    int n;
    logic [31:0] w;
    n = int'(fq[0]) + 256 * int'(fq[1]);
    eq.delete();
    exp_err = (n > depth);
    exp_run = !exp_err;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        w = {fq[2+4*k+3], fq[2+4*k+2], fq[2+4*k+1], fq[2+4*k]};
        eq.push_back({8'(k), w});
      end
    end
  endtask

  task automatic check_writes(input bit sel, input string tag);
    logic [39:0] q[$];
    int lim;
    if (sel) q = sq;
    else     q = mq;
    check_output({tag, "_count"}, 64'(q.size()), 64'(eq.size()));
    lim = (q.size() < eq.size()) ? q.size() : eq.size();
    for (int i = 0; i < lim; i++) check_output($sformatf("%s_w%0d", tag, i), 64'(q[i]), 64'(eq[i]));
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    idle(1);
    load_req = 1'b0;
    idle(1);
    mq.delete();
    sq.delete();
  endtask

  initial begin
    reset    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    load_req = 1'b0;
    #12;
    check_output("rst_wr_en",       64'(m_wr_en),       64'd0);
    check_output("rst_wr_addr",     64'(m_wr_addr),     64'd0);
    check_output("rst_wr_data",     64'(m_wr_data),     64'd0);
    check_output("rst_core_reset",  64'(m_core_reset),  64'd1);
    check_output("rst_load_done",   64'(m_load_done),   64'd0);
    check_output("rst_frame_error", 64'(m_frame_error), 64'd0);
    check_output("rst_in_ready",    64'(m_in_ready),    64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    $display("[TB] single word frame");
    fq = '{8'h01, 8'h00, 8'h93, 8'h02, 8'hC0, 8'h00};
    send_frame(0, 0);
    check_output("w1_wr_en",       64'(m_wr_en),      64'd1);
    check_output("w1_wr_addr",     64'(m_wr_addr),    64'd0);
    check_output("w1_wr_data",     64'(m_wr_data),    64'h00C00293);
    check_output("w1_core_reset",  64'(m_core_reset), 64'd1);
    idle(1);
    check_output("w1_wr_en_off",   64'(m_wr_en),      64'd0);
    check_output("w1_core_release",64'(m_core_reset), 64'd0);
    check_output("w1_load_done",   64'(m_load_done),  64'd1);
    check_output("w1_in_ready",    64'(m_in_ready),   64'd0);
    pulse_load_req();

    $display("[TB] two word frame with gaps");
    fq = '{8'h02, 8'h00, 8'h93, 8'h02, 8'hC0, 8'h00, 8'h93, 8'h02, 8'h80, 8'h0C};
    send_frame(0, 1);
    idle(3);
    build_model(256);
    check_writes(0, "w2");
    check_output("w2_load_done", 64'(m_load_done), 64'd1);
    pulse_load_req();

    $display("[TB] empty frame");
    fq = '{8'h00, 8'h00};
    send_frame(0, 0);
    check_output("n0_core_reset", 64'(m_core_reset), 64'd0);
    check_output("n0_load_done",  64'(m_load_done),  64'd1);
    idle(2);
    check_output("n0_writes",     64'(mq.size()),    64'd0);
    pulse_load_req();

    $display("[TB] oversize frame on small instance");
    fq = '{8'h05, 8'h00};
    send_frame(1, 0);
    check_output("err_frame_error", 64'(s_frame_error), 64'd1);
    check_output("err_in_ready",    64'(s_in_ready),    64'd0);
    check_output("err_core_reset",  64'(s_core_reset),  64'd1);
    idle(3);
    check_output("err_writes",      64'(sq.size()),     64'd0);
    pulse_load_req();
    check_output("err_clr_frame_error", 64'(s_frame_error), 64'd0);
    check_output("err_clr_in_ready",    64'(s_in_ready),    64'd1);
    check_output("err_clr_core_reset",  64'(s_core_reset),  64'd1);

    $display("[TB] full-depth frame on small instance");
    make_random_frame(4);
    send_frame(1, 1);
    idle(3);
    build_model(4);
    check_writes(1, "full4");
    check_output("full4_load_done", 64'(s_load_done), 64'd1);
    pulse_load_req();

    $display("[TB] reset mid-frame");
    fq = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_frame(0, 0);
    #2 reset = 1'b0;
    #1;
    check_output("amid_core_reset", 64'(m_core_reset), 64'd1);
    check_output("amid_in_ready",   64'(m_in_ready),   64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    mq.delete();
    sq.delete();
    fq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    send_frame(0, 0);
    idle(3);
    build_model(256);
    check_writes(0, "amid");
    load_req = 1'b1;
    idle(1);
    load_req = 1'b0;
    check_output("run_req_core_reset", 64'(m_core_reset), 64'd1);
    check_output("run_req_load_done",  64'(m_load_done),  64'd0);
    idle(1);
    mq.delete();
    sq.delete();

    $display("[TB] load_req beats a simultaneous byte");
    in_byte  = 8'h05;
    in_valid = 1'b1;
    load_req = 1'b1;
    idle(1);
    in_valid = 1'b0;
    load_req = 1'b0;
    fq = '{8'h00, 8'h00};
    send_frame(0, 0);
    check_output("coll_load_done", 64'(m_load_done), 64'd1);
    pulse_load_req();

    $display("[TB] randomized frames");
    for (int r = 0; r < 10; r++) begin
      int n;
      if (r == 8)      n = 256;
      else if (r == 9) n = 257;
      else             n = $urandom_range(1, 8);
      if (n == 257) begin
        fq = '{8'h01, 8'h01};
      end else begin
        make_random_frame(n);
      end
      send_frame(0, ($urandom_range(0, 1) == 1));
      idle(3);
      build_model(256);
      check_writes(0, $sformatf("rnd%0d", r));
      check_output($sformatf("rnd%0d_load_done", r),   64'(m_load_done),   64'(exp_run));
      check_output($sformatf("rnd%0d_frame_error", r), 64'(m_frame_error), 64'(exp_err));
      pulse_load_req();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
